// File: rtl/rx_source_arbiter.sv
`timescale 1ns/1ps
// Shares one byte-stream sink between a UART (A) and SPI (B) receiver: per-source
// skid FIFOs, command-locked round-robin grant, and paced single-cycle output strobes.

module rx_skid_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_in,
    input  logic       rstb,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       rd_en,
    output logic [7:0] head,
    output logic       empty,
    output logic       overflow_evt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          do_wr;
    logic          do_rd;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign do_rd        = rd_en && !empty;
    // A pop on the same edge frees a slot, so a full FIFO still takes the byte.
    assign do_wr        = wr_en && (!full || do_rd);
    assign overflow_evt = wr_en && !do_wr;
    assign head         = mem[rd_ptr];

    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

module rx_source_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int IDLE_TIMEOUT = 64,
    parameter int BYTE_GAP     = 4
) (
    input  logic       clk_in,
    input  logic       rstb,
    input  logic [7:0] a_data,
    input  logic       a_valid,
    input  logic [7:0] b_data,
    input  logic       b_valid,
    input  logic       ovf_clear,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       grant_a,
    output logic       grant_b,
    output logic       a_overflow,
    output logic       b_overflow
);
    // state  | meaning
    // IDLE   | no lock held; arbitrate between non-empty FIFOs
    // LOCK_A | source A owns the output until its stream goes quiet
    // LOCK_B | source B owns the output until its stream goes quiet
    typedef enum logic [1:0] {IDLE = 2'd0, LOCK_A = 2'd1, LOCK_B = 2'd2} state_t;

    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int GW = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(BYTE_GAP - 1);

    state_t        state;
    state_t        state_nxt;
    logic          last_b;
    logic [GW-1:0] gap_cnt;
    logic [IW-1:0] idle_cnt;
    logic          pop_a;
    logic          pop_b;
    logic          src_active;
    logic          timeout;
    logic          a_empty;
    logic          b_empty;
    logic          a_ovf_evt;
    logic          b_ovf_evt;
    logic [7:0]    a_head;
    logic [7:0]    b_head;

    rx_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk_in       (clk_in),
        .rstb         (rstb),
        .wr_data      (a_data),
        .wr_en        (a_valid),
        .rd_en        (pop_a),
        .head         (a_head),
        .empty        (a_empty),
        .overflow_evt (a_ovf_evt)
    );

    rx_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk_in       (clk_in),
        .rstb         (rstb),
        .wr_data      (b_data),
        .wr_en        (b_valid),
        .rd_en        (pop_b),
        .head         (b_head),
        .empty        (b_empty),
        .overflow_evt (b_ovf_evt)
    );

    assign timeout = (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // last_b set means A wins a tie
                if (!a_empty && (b_empty || last_b)) state_nxt = LOCK_A;
                else if (!b_empty)                  state_nxt = LOCK_B;
            end
            LOCK_A, LOCK_B: begin
                if (timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_a    = (state == LOCK_A);
        grant_b    = (state == LOCK_B);
        pop_a      = grant_a && !a_empty && (gap_cnt == '0);
        pop_b      = grant_b && !b_empty && (gap_cnt == '0);
        src_active = grant_a ? (a_valid || !a_empty) : (b_valid || !b_empty);
    end

    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            last_b     <= 1'b1;
            gap_cnt    <= '0;
            idle_cnt   <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            a_overflow <= 1'b0;
            b_overflow <= 1'b0;
        end else begin
            if (state_nxt == LOCK_A)      last_b <= 1'b0;
            else if (state_nxt == LOCK_B) last_b <= 1'b1;

            if (pop_a || pop_b)       gap_cnt <= GAP_LOAD;
            else if (gap_cnt != '0)   gap_cnt <= gap_cnt - GW'(1);

            if (state == IDLE || src_active) idle_cnt <= '0;
            else if (!timeout)               idle_cnt <= idle_cnt + IW'(1);

            data_valid <= pop_a || pop_b;
            if (pop_a)      data_out <= a_head;
            else if (pop_b) data_out <= b_head;

            if (a_ovf_evt)      a_overflow <= 1'b1;
            else if (ovf_clear) a_overflow <= 1'b0;
            if (b_ovf_evt)      b_overflow <= 1'b1;
            else if (ovf_clear) b_overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rx_source_arbiter.sv
`timescale 1ns/1ps
// Bench for rx_source_arbiter: directed scenarios with hand-computed strobe
// schedules, then randomized traffic compared every cycle to a queue-based model.
module tb_rx_source_arbiter;
    localparam int DEPTH = 4;
    localparam int TMO   = 64;
    localparam int GAP   = 4;

    logic       clk_in    = 1'b0;
    logic       rstb      = 1'b1;
    logic [7:0] a_data    = 8'h00;
    logic [7:0] b_data    = 8'h00;
    logic       a_valid   = 1'b0;
    logic       b_valid   = 1'b0;
    logic       ovf_clear = 1'b0;

    logic [7:0] data_out, data_out1;
    logic       data_valid, grant_a, grant_b, a_overflow, b_overflow;
    logic       data_valid1, grant_a1, grant_b1, a_overflow1, b_overflow1;

    rx_source_arbiter #(.FIFO_DEPTH(DEPTH), .IDLE_TIMEOUT(TMO), .BYTE_GAP(GAP)) dut (
        .clk_in(clk_in), .rstb(rstb), .a_data(a_data), .a_valid(a_valid),
        .b_data(b_data), .b_valid(b_valid), .ovf_clear(ovf_clear),
        .data_out(data_out), .data_valid(data_valid), .grant_a(grant_a),
        .grant_b(grant_b), .a_overflow(a_overflow), .b_overflow(b_overflow)
    );

    rx_source_arbiter #(.FIFO_DEPTH(DEPTH), .IDLE_TIMEOUT(TMO), .BYTE_GAP(1)) dut_g1 (
        .clk_in(clk_in), .rstb(rstb), .a_data(a_data), .a_valid(a_valid),
        .b_data(b_data), .b_valid(b_valid), .ovf_clear(ovf_clear),
        .data_out(data_out1), .data_valid(data_valid1), .grant_a(grant_a1),
        .grant_b(grant_b1), .a_overflow(a_overflow1), .b_overflow(b_overflow1)
    );

    always #5 clk_in = ~clk_in;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    bit         cmp_en   = 1'b0;
    int         lg_t[$], lg1_t[$], eq_t[$];
    logic [7:0] lg_d[$], lg1_d[$], eq_d[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queues for the FIFOs, 0/1/2 for none/A/B owning the output.
    int         m_state = 0, m_last = 2, m_gap = 0, m_idle = 0;
    logic [7:0] qa[$], qb[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_dv = 1'b0, m_aovf = 1'b0, m_bovf = 1'b0;

    function automatic void model_step();
        bit ne_a, ne_b, pop, xv, xne, ev_a, ev_b;
        ne_a = (qa.size() > 0);
        ne_b = (qb.size() > 0);
        pop  = ((m_state == 1 && ne_a) || (m_state == 2 && ne_b)) && (m_gap == 0);
        m_dv = pop;
        if (pop) m_dout = (m_state == 1) ? qa.pop_front() : qb.pop_front();
        m_gap = pop ? GAP - 1 : (m_gap > 0 ? m_gap - 1 : 0);
        ev_a = 1'b0;
        ev_b = 1'b0;
        if (a_valid) begin
            if (qa.size() < DEPTH) qa.push_back(a_data); else ev_a = 1'b1;
        end
        if (b_valid) begin
            if (qb.size() < DEPTH) qb.push_back(b_data); else ev_b = 1'b1;
        end
        m_aovf = ev_a | (m_aovf & !ovf_clear);
        m_bovf = ev_b | (m_bovf & !ovf_clear);
        if (m_state == 0) begin
            m_idle = 0;
            if (ne_a && ne_b) m_state = (m_last == 2) ? 1 : 2;
            else if (ne_a)    m_state = 1;
            else if (ne_b)    m_state = 2;
            if (m_state != 0) m_last = m_state;
        end else begin
            xv  = (m_state == 1) ? a_valid : b_valid;
            xne = (m_state == 1) ? ne_a : ne_b;
            if (m_idle == TMO - 1) begin
                m_state = 0;
                m_idle  = 0;
            end else if (xv || xne) m_idle = 0;
            else m_idle++;
        end
    endfunction

    always @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            qa.delete(); qb.delete();
            m_state = 0; m_last = 2; m_gap = 0; m_idle = 0;
            m_dout = 8'h00; m_dv = 1'b0; m_aovf = 1'b0; m_bovf = 1'b0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk_in) begin
        if (cmp_en && rstb)
            check("model_cmp",
                  {data_out, data_valid, grant_a, grant_b, a_overflow, b_overflow},
                  {m_dout, m_dv, m_state == 1, m_state == 2, m_aovf, m_bovf});
    end

    task automatic tick();
        @(negedge clk_in);
        cyc++;
        if (data_valid)  begin lg_t.push_back(cyc);  lg_d.push_back(data_out);  end
        if (data_valid1) begin lg1_t.push_back(cyc); lg1_d.push_back(data_out1); end
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic put_a(input logic [7:0] d);
        a_data = d; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic expect_strobe(input int t, input logic [7:0] d);
        eq_t.push_back(t);
        eq_d.push_back(d);
    endtask

    task automatic check_log(input string name);
        check($sformatf("%s_count", name), lg_t.size(), eq_t.size());
        for (int i = 0; i < eq_t.size() && i < lg_t.size(); i++) begin
            check($sformatf("%s_time%0d", name, i), lg_t[i], eq_t[i]);
            check($sformatf("%s_data%0d", name, i), {24'h0, lg_d[i]}, {24'h0, eq_d[i]});
        end
        lg_t.delete(); lg_d.delete(); eq_t.delete(); eq_d.delete();
    endtask

    task automatic do_reset();
        a_valid = 1'b0; b_valid = 1'b0; ovf_clear = 1'b0;
        #2 rstb = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rstb = 1'b1;
        cyc  = 0;
        lg_t.delete(); lg_d.delete(); lg1_t.delete(); lg1_d.delete();
        eq_t.delete(); eq_d.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int dens[4];
        int pa, pb;
        dens[0] = 0; dens[1] = 3; dens[2] = 15; dens[3] = 60;

        // Single A stream, idle-timeout boundary and re-arbitration
        do_reset();
        cmp_en = 1'b1;
        check("reset_state",
              {data_out, data_valid, grant_a, grant_b, a_overflow, b_overflow,
               data_out1, data_valid1, grant_a1, grant_b1, a_overflow1, b_overflow1}, 0);
        put_a(8'h4C);
        to_cyc(2);   check("t1_grant_a", {grant_a, grant_b}, 2'b10);
        to_cyc(65);  put_a(8'h2D);
        to_cyc(67);  check("t6_hold", grant_a, 1'b1);
        to_cyc(130); check("t6_last_held", grant_a, 1'b1);
        to_cyc(131); check("t6_release", {grant_a, grant_b}, 2'b00);
        put_a(8'h31);
        to_cyc(133); check("t6_regrant", {grant_a, grant_b}, 2'b10);
        to_cyc(140);
        expect_strobe(3, 8'h4C); expect_strobe(67, 8'h2D); expect_strobe(134, 8'h31);
        check_log("t1_strobes");

        // Simultaneous A and B from reset: A first, one IDLE cycle, then B
        do_reset();
        a_data = 8'hAA; b_data = 8'h55; a_valid = 1'b1; b_valid = 1'b1;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        to_cyc(2);  check("t2_first_grant", {grant_a, grant_b}, 2'b10);
        to_cyc(67); check("t2_idle_gap", {grant_a, grant_b}, 2'b00);
        to_cyc(68); check("t2_second_grant", {grant_a, grant_b}, 2'b01);
        to_cyc(72); check("t2_no_ovf", {a_overflow, b_overflow}, 2'b00);
        expect_strobe(3, 8'hAA); expect_strobe(69, 8'h55);
        check_log("t2_strobes");

        // B burst overflows while A is locked; clear afterwards
        do_reset();
        put_a(8'h11); put_a(8'h22);
        for (int i = 0; i < 6; i++) begin
            b_data = 8'(i + 1); b_valid = 1'b1;
            tick();
            if (cyc == 6) check("t3_no_ovf_yet", b_overflow, 1'b0);
            if (cyc == 7) check("t3_ovf_set", b_overflow, 1'b1);
        end
        b_valid = 1'b0;
        to_cyc(71); check("t3_idle", {grant_a, grant_b}, 2'b00);
        to_cyc(90); check("t3_ovf_sticky", {a_overflow, b_overflow}, 2'b01);
        ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
        check("t3_ovf_cleared", b_overflow, 1'b0);
        expect_strobe(3, 8'h11);  expect_strobe(7, 8'h22);  expect_strobe(73, 8'h01);
        expect_strobe(77, 8'h02); expect_strobe(81, 8'h03); expect_strobe(85, 8'h04);
        check_log("t3_strobes");

        // Pacing: BYTE_GAP=4 instance and BYTE_GAP=1 instance
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_data = 8'hC0 + 8'(i); a_valid = 1'b1;
            tick();
        end
        a_valid = 1'b0;
        to_cyc(5);  check("t4_hold_between", {data_valid, data_out}, {1'b0, 8'hC0});
        to_cyc(20);
        check("t4_g1_count", lg1_t.size(), 4);
        for (int i = 0; i < 4 && i < lg1_t.size(); i++) begin
            check($sformatf("t4_g1_time%0d", i), lg1_t[i], 3 + i);
            check($sformatf("t4_g1_data%0d", i), {24'h0, lg1_d[i]}, 32'hC0 + i);
        end
        for (int i = 0; i < 4; i++) expect_strobe(3 + 4 * i, 8'hC0 + 8'(i));
        check_log("t4_strobes");

        // Asynchronous reset mid-stream discards buffered bytes
        do_reset();
        put_a(8'hE1); put_a(8'hE2); put_a(8'hE3);
        check("t5_pre", {grant_a, data_valid, data_out}, {1'b1, 1'b1, 8'hE1});
        #2 rstb = 1'b0;
        #1 check("t5_async_zero",
                 {data_out, data_valid, grant_a, grant_b, a_overflow, b_overflow,
                  data_out1, data_valid1, grant_a1, grant_b1, a_overflow1, b_overflow1}, 0);
        @(negedge clk_in);
        rstb = 1'b1; cyc = 0;
        lg_t.delete(); lg_d.delete();
        to_cyc(100);
        check("t5_no_stale", lg_t.size(), 0);

        // Randomized traffic, checked every cycle by the model
        for (int blk = 0; blk < 12; blk++) begin
            if (blk == 6) do_reset();
            pa = dens[$urandom_range(0, 3)];
            pb = dens[$urandom_range(0, 3)];
            for (int c = 0; c < 250; c++) begin
                a_valid   = ($urandom_range(0, 99) < pa);
                b_valid   = ($urandom_range(0, 99) < pb);
                a_data    = 8'($urandom);
                b_data    = 8'($urandom);
                ovf_clear = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        a_valid = 1'b0; b_valid = 1'b0; ovf_clear = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
